// File: rtl/axi3_pkg.sv
// Shared AXI3 constants and the read-arbiter issue FSM state type.
package axi3_pkg;

  localparam int AXI_ID_W  = 6;
  localparam int AXI_LEN_W = 4;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

  typedef enum logic [0:0] {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// NUM must be a power of two so the index addition wraps naturally.
module rr_arbiter #(
  parameter int NUM = 4,
  localparam int IDX_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]   req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NUM-1:0]   gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset back to ptr_i so the nearest request wins last.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      cand = ptr_i + IDX_W'(k);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/axi3_read_arbiter.sv
// Shares one AXI3 read port between NUM_REQ burst requesters: round-robin AR
// issue with per-requester ARID, RID-based R routing, length/response checking.
module axi3_read_arbiter
  import axi3_pkg::*;
#(
  parameter int                    NUM_REQ = 4,
  parameter logic [AXI_ID_W-1:0]   ID_BASE = 6'h10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [32*NUM_REQ-1:0]    req_addr,
  input  logic [4*NUM_REQ-1:0]     req_len,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [31:0]              resp_data,
  output logic                     resp_last,
  output logic [NUM_REQ-1:0]       resp_err,
  output logic                     protocol_err,
  output logic                     d_arvalid,
  input  logic                     d_arready,
  output logic [31:0]              d_araddr,
  output logic [AXI_LEN_W-1:0]     d_arlen,
  output logic [AXI_ID_W-1:0]      d_arid,
  output logic [1:0]               d_arburst,
  output logic [2:0]               d_arsize,
  output logic [1:0]               d_arlock,
  output logic [3:0]               d_arcache,
  output logic [2:0]               d_arprot,
  output logic [3:0]               d_arqos,
  input  logic                     d_rvalid,
  output logic                     d_rready,
  input  logic [31:0]              d_rdata,
  input  logic [1:0]               d_rresp,
  input  logic                     d_rlast,
  input  logic [AXI_ID_W-1:0]      d_rid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [AXI_ID_W-1:0] ID_MASK = ~AXI_ID_W'(NUM_REQ - 1);

  ar_state_e state_q, state_d;

  logic [NUM_REQ-1:0]                busy_q, busy_d;
  logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][AXI_LEN_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0][AXI_LEN_W-1:0] exp_len_q, exp_len_d;
  logic [NUM_REQ-1:0]                resp_err_q, resp_err_d;
  logic                              perr_q, perr_d;
  logic [31:0]                       araddr_q, araddr_d;
  logic [AXI_LEN_W-1:0]              arlen_q, arlen_d;
  logic [AXI_ID_W-1:0]               arid_q, arid_d;

  logic [31:0]          addr_arr [NUM_REQ];
  logic [AXI_LEN_W-1:0] len_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible, gnt;
  logic [IDX_W-1:0]     gnt_idx, r_idx;
  logic                 grant_fire, hit, hit_fire, miss_beat;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*32 +: 32];
    assign len_arr[gi]  = req_len[gi*4 +: 4];
  end

  // Registered busy keeps a requester out until its RLAST has been consumed.
  assign eligible = req_valid & ~busy_q;

  rr_arbiter #(.NUM(NUM_REQ)) u_rr (
    .req_i     (eligible),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // AR FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= AR_IDLE;
    else       state_q <= state_d;
  end

  // AR FSM next state; grants only in IDLE, so issues are at least two cycles apart.
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    case (state_q)
      AR_IDLE: begin
        grant_fire = |eligible;
        if (grant_fire) state_d = AR_ISSUE;
      end
      AR_ISSUE: begin
        if (d_arready) state_d = AR_IDLE;
      end
    endcase
  end

  assign req_ready = grant_fire ? gnt : '0;
  assign d_arvalid = (state_q == AR_ISSUE);
  assign d_araddr  = araddr_q;
  assign d_arlen   = arlen_q;
  assign d_arid    = arid_q;
  assign d_arburst = AXI_BURST_INCR;
  assign d_arsize  = AXI_SIZE_4B;
  assign d_arlock  = 2'b00;
  assign d_arcache = AXI_CACHE_DEFAULT;
  assign d_arprot  = 3'b000;
  assign d_arqos   = 4'b0000;

  // R routing: zero-latency steer by RID; unknown or idle IDs are drained.
  always_comb begin
    r_idx      = d_rid[IDX_W-1:0];
    hit        = ((d_rid & ID_MASK) == ID_BASE) && busy_q[r_idx];
    resp_valid = (hit && d_rvalid) ? (NUM_REQ'(1) << r_idx) : '0;
    resp_data  = d_rdata;
    resp_last  = hit && d_rlast;
    d_rready   = hit ? resp_ready[r_idx] : 1'b1;
    hit_fire   = hit && d_rvalid && resp_ready[r_idx];
    miss_beat  = !hit && d_rvalid;
  end

  // Bookkeeping next state: grant capture, beat counting and sticky error flags.
  always_comb begin
    busy_d     = busy_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    exp_len_d  = exp_len_q;
    resp_err_d = resp_err_q;
    perr_d     = perr_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arid_d     = arid_q;
    if (grant_fire) begin
      busy_d[gnt_idx]    = 1'b1;
      exp_len_d[gnt_idx] = len_arr[gnt_idx];
      cnt_d[gnt_idx]     = '0;
      rr_ptr_d           = gnt_idx + IDX_W'(1);
      araddr_d           = addr_arr[gnt_idx];
      arlen_d            = len_arr[gnt_idx];
      arid_d             = ID_BASE | AXI_ID_W'(gnt_idx);
    end
    // A granted requester was not busy, so this never touches the same index as the grant.
    if (hit_fire) begin
      cnt_d[r_idx] = cnt_q[r_idx] + AXI_LEN_W'(1);
      if (d_rresp != AXI_RESP_OKAY) resp_err_d[r_idx] = 1'b1;
      if (d_rlast) begin
        busy_d[r_idx] = 1'b0;
        if (cnt_q[r_idx] != exp_len_q[r_idx]) perr_d = 1'b1;
      end else if (cnt_q[r_idx] == exp_len_q[r_idx]) begin
        perr_d = 1'b1;
      end
    end
    if (miss_beat) perr_d = 1'b1;
  end

  // Bookkeeping registers; reset abandons any in-flight bursts.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q     <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      exp_len_q  <= '0;
      resp_err_q <= '0;
      perr_q     <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
    end else begin
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      exp_len_q  <= exp_len_d;
      resp_err_q <= resp_err_d;
      perr_q     <= perr_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arid_q     <= arid_d;
    end
  end

  assign resp_err     = resp_err_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_axi3_read_arbiter.sv
// Bench for axi3_read_arbiter: directed AR/R traffic, a cycle-level reference
// model checked every cycle, and literal expectations for each scenario.
module tb_axi3_read_arbiter;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [32*N-1:0] req_addr = '0;
  logic [4*N-1:0] req_len = '0;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready = '1;
  logic [31:0]    resp_data;
  logic           resp_last;
  logic [N-1:0]   resp_err;
  logic           protocol_err;
  logic           d_arvalid;
  logic           d_arready = 1'b0;
  logic [31:0]    d_araddr;
  logic [3:0]     d_arlen;
  logic [5:0]     d_arid;
  logic [1:0]     d_arburst;
  logic [2:0]     d_arsize;
  logic [1:0]     d_arlock;
  logic [3:0]     d_arcache;
  logic [2:0]     d_arprot;
  logic [3:0]     d_arqos;
  logic           d_rvalid = 1'b0;
  logic           d_rready;
  logic [31:0]    d_rdata = '0;
  logic [1:0]     d_rresp = '0;
  logic           d_rlast = 1'b0;
  logic [5:0]     d_rid = '0;

  axi3_read_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err), .protocol_err(protocol_err),
    .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddr(d_araddr), .d_arlen(d_arlen),
    .d_arid(d_arid), .d_arburst(d_arburst), .d_arsize(d_arsize), .d_arlock(d_arlock),
    .d_arcache(d_arcache), .d_arprot(d_arprot), .d_arqos(d_arqos),
    .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rdata(d_rdata), .d_rresp(d_rresp),
    .d_rlast(d_rlast), .d_rid(d_rid)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (bench view of the rules) ----------------
  bit          chk_en = 1'b0;
  bit          m_issue = 1'b0;
  logic [31:0] m_araddr = '0;
  logic [3:0]  m_arlen = '0;
  logic [5:0]  m_arid = '0;
  logic [N-1:0] m_busy = '0;
  logic [N-1:0] m_rerr = '0;
  logic        m_perr = 1'b0;
  int          m_ptr = 0;
  int          m_cnt [N];
  int          m_exp [N];

  int glog[$];
  int gcyc[$];
  int hs_cnt [N];

  always @(negedge clock) begin
    int g, j, ridx;
    logic [N-1:0] e_rr, e_rv;
    logic e_rready;
    bit hit, hs;
    cyc++;
    // Who should be granted: first non-busy valid requester at or after the pointer.
    g = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (g < 0 && req_valid[j] && !m_busy[j]) g = j;
    end
    e_rr = '0;
    if (!m_issue && g >= 0) e_rr[g] = 1'b1;
    // Where should the current R beat go.
    ridx = int'(d_rid) % N;
    hit = ((int'(d_rid) - ridx) == 'h10) && m_busy[ridx];
    e_rv = '0;
    e_rready = 1'b1;
    if (hit) begin
      e_rready = resp_ready[ridx];
      if (d_rvalid) e_rv[ridx] = 1'b1;
    end
    hs = d_rvalid && e_rready;

    if (chk_en) begin
      chk("req_ready", req_ready, e_rr);
      chk("arvalid", d_arvalid, m_issue);
      if (m_issue) begin
        chk("araddr", d_araddr, m_araddr);
        chk("arlen", d_arlen, m_arlen);
        chk("arid", d_arid, m_arid);
      end
      chk("ar_const", {d_arburst, d_arsize, d_arlock, d_arcache, d_arprot, d_arqos},
          {2'b01, 3'b010, 2'b00, 4'b0011, 3'b000, 4'b0000});
      chk("resp_valid", resp_valid, e_rv);
      chk("rready", d_rready, e_rready);
      if (e_rv != 0) begin
        chk("resp_data", resp_data, d_rdata);
        chk("resp_last", resp_last, d_rlast);
      end
      chk("resp_err", resp_err, m_rerr);
      chk("protocol_err", protocol_err, m_perr);
    end

    // Observed DUT activity for the directed checks.
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        glog.push_back(i);
        gcyc.push_back(cyc);
      end
      if (resp_valid[i] && resp_ready[i]) hs_cnt[i]++;
    end

    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      m_issue = 1'b0;
      m_busy  = '0;
      m_rerr  = '0;
      m_perr  = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      chk_en  = 1'b1;
    end else begin
      if (hs) begin
        if (hit) begin
          $display("R  rid=%02h data=%08h resp=%0d last=%0b -> requester %0d",
                   d_rid, d_rdata, d_rresp, d_rlast, ridx);
          if (d_rresp != 2'b00) m_rerr[ridx] = 1'b1;
          // Beats seen so far, including this one, against ARLEN+1.
          if (d_rlast) begin
            if (m_cnt[ridx] + 1 != m_exp[ridx] + 1) m_perr = 1'b1;
            m_busy[ridx] = 1'b0;
          end else if (m_cnt[ridx] + 1 >= m_exp[ridx] + 1) begin
            m_perr = 1'b1;
          end
          m_cnt[ridx]++;
        end else begin
          $display("R  rid=%02h data=%08h dropped (no owner)", d_rid, d_rdata);
          m_perr = 1'b1;
        end
      end
      if (m_issue) begin
        if (d_arready) begin
          $display("AR id=%02h addr=%08h len=%0d", m_arid, m_araddr, m_arlen);
          m_issue = 1'b0;
        end
      end else if (g >= 0) begin
        m_issue  = 1'b1;
        m_araddr = req_addr[g*32 +: 32];
        m_arlen  = req_len[g*4 +: 4];
        m_arid   = 6'h10 + 6'(g);
        m_busy[g] = 1'b1;
        m_exp[g] = int'(req_len[g*4 +: 4]);
        m_cnt[g] = 0;
        m_ptr    = (g + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int count_grants(input int idx);
    int c = 0;
    foreach (glog[k]) if (glog[k] == idx) c++;
    return c;
  endfunction

  // Raise one request, expect its grant, then hold AR for 'hold' cycles before accepting.
  task automatic issue(input int idx, input logic [31:0] addr, input logic [3:0] len, input int hold);
    int n;
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    req_addr[idx*32 +: 32] = addr;
    req_len[idx*4 +: 4]    = len;
    req_valid[idx]         = 1'b1;
    n = 0;
    @(negedge clock);
    while (req_ready == 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("grant", req_ready, oh);
    @(posedge clock); #1;
    req_valid[idx] = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) d_arready = 1'b1;
      @(negedge clock);
      chk("issue_arvalid", d_arvalid, 1'b1);
      chk("issue_arid", d_arid, 6'h10 + 6'(idx));
      chk("issue_araddr", d_araddr, addr);
      chk("issue_arlen", d_arlen, len);
      @(posedge clock); #1;
    end
    d_arready = 1'b0;
  endtask

  // Present one R beat; the owner stalls for 'stall' cycles before accepting.
  task automatic beat(input logic [5:0] rid, input logic [31:0] data, input logic [1:0] resp,
                      input logic last, input logic [N-1:0] exp_rv, input int stall);
    d_rvalid = 1'b1;
    d_rid    = rid;
    d_rdata  = data;
    d_rresp  = resp;
    d_rlast  = last;
    if (stall > 0) resp_ready = ~exp_rv;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      chk("stall_rready", d_rready, 1'b0);
      chk("stall_valid", resp_valid, exp_rv);
      chk("stall_data", resp_data, data);
      @(posedge clock); #1;
    end
    resp_ready = '1;
    @(negedge clock);
    chk("beat_valid", resp_valid, exp_rv);
    chk("beat_rready", d_rready, 1'b1);
    if (exp_rv != 0) begin
      chk("beat_data", resp_data, data);
      chk("beat_last", resp_last, last);
    end
    @(posedge clock); #1;
    d_rvalid = 1'b0;
    d_rlast  = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base, h0, h1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_arvalid", d_arvalid, 1'b0);
    chk("rst_resp_err", resp_err, 4'b0000);
    chk("rst_protocol_err", protocol_err, 1'b0);
    @(posedge clock); #1;

    // All four requesting continuously with AR always ready.
    d_arready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32] = 32'h2000_0000 + 32'(i * 'h100);
      req_len[i*4 +: 4]    = 4'd0;
    end
    req_valid = 4'hF;
    for (int n = 0; n < 40 && glog.size() < 4; n++) begin
      @(negedge clock); #1;
    end
    repeat (6) begin
      @(negedge clock); #1;
    end
    chk("rr_count_no_regrant", glog.size(), 4);
    if (glog.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", glog[k], k);
      for (int k = 0; k < 3; k++) chk("rr_spacing", gcyc[k+1] - gcyc[k], 2);
    end
    @(posedge clock); #1;
    beat(6'h10, 32'hA0A0_0000, 2'b00, 1'b1, 4'b0001, 0);
    for (int n = 0; n < 20 && glog.size() < 5; n++) begin
      @(negedge clock); #1;
    end
    chk("regrant_req0", (glog.size() >= 5) ? glog[4] : -1, 0);
    @(posedge clock); #1;
    req_valid = '0;
    @(posedge clock); #1;
    d_arready = 1'b0;
    beat(6'h11, 32'hA0A0_0001, 2'b00, 1'b1, 4'b0010, 0);
    beat(6'h12, 32'hA0A0_0002, 2'b00, 1'b1, 4'b0100, 0);
    beat(6'h13, 32'hA0A0_0003, 2'b00, 1'b1, 4'b1000, 0);
    beat(6'h10, 32'hA0A0_0004, 2'b00, 1'b1, 4'b0001, 0);
    chk("rr_no_perr", protocol_err, 1'b0);

    // Single request with AR backpressure.
    base = count_grants(1);
    h1 = hs_cnt[1];
    issue(1, 32'h1000_0040, 4'd3, 2);
    for (int b = 0; b < 4; b++)
      beat(6'h11, 32'hB000_0000 + 32'(b), 2'b00, (b == 3), 4'b0010, 0);
    chk("single_pulses", count_grants(1) - base, 1);
    chk("single_beats", hs_cnt[1] - h1, 4);
    chk("single_resp_err", resp_err, 4'b0000);
    chk("single_perr", protocol_err, 1'b0);

    // Interleaved returns across two requesters.
    issue(0, 32'h3000_0000, 4'd1, 0);
    issue(2, 32'h3000_1000, 4'd0, 0);
    beat(6'h12, 32'hC000_0000, 2'b00, 1'b1, 4'b0100, 0);
    beat(6'h10, 32'hC000_0001, 2'b00, 1'b0, 4'b0001, 0);
    beat(6'h10, 32'hC000_0002, 2'b00, 1'b1, 4'b0001, 0);
    chk("interleave_perr", protocol_err, 1'b0);

    // Requester backpressure mid-burst.
    h0 = hs_cnt[0];
    issue(0, 32'h4000_0000, 4'd2, 0);
    beat(6'h10, 32'hD000_0000, 2'b00, 1'b0, 4'b0001, 0);
    beat(6'h10, 32'hD000_0001, 2'b00, 1'b0, 4'b0001, 3);
    beat(6'h10, 32'hD000_0002, 2'b00, 1'b1, 4'b0001, 0);
    chk("bp_beats", hs_cnt[0] - h0, 3);
    chk("bp_perr", protocol_err, 1'b0);

    // Error response and unknown RID.
    issue(3, 32'h5000_0000, 4'd0, 0);
    beat(6'h13, 32'hE000_0000, 2'b10, 1'b1, 4'b1000, 0);
    chk("rresp_err", resp_err, 4'b1000);
    chk("rresp_no_perr", protocol_err, 1'b0);
    beat(6'h05, 32'hE000_0001, 2'b00, 1'b1, 4'b0000, 0);
    chk("unknown_rid_perr", protocol_err, 1'b1);
    chk("unknown_rid_err", resp_err, 4'b1000);

    // Reset in the middle of a burst.
    issue(2, 32'h6000_0000, 4'd3, 0);
    beat(6'h12, 32'hF000_0000, 2'b00, 1'b0, 4'b0100, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_req_ready", req_ready, 4'b0000);
    chk("mid_rst_arvalid", d_arvalid, 1'b0);
    chk("mid_rst_resp_err", resp_err, 4'b0000);
    chk("mid_rst_perr", protocol_err, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 4'b0000);
    @(posedge clock); #1;

    // Early RLAST after reset, then requester 1 must be grantable again.
    issue(1, 32'h7000_0000, 4'd3, 1);
    beat(6'h11, 32'h7700_0000, 2'b00, 1'b0, 4'b0010, 0);
    beat(6'h11, 32'h7700_0001, 2'b00, 1'b1, 4'b0010, 0);
    chk("short_last_perr", protocol_err, 1'b1);
    chk("short_last_resp_err", resp_err, 4'b0000);
    issue(1, 32'h7000_0100, 4'd0, 0);
    beat(6'h11, 32'h7700_0002, 2'b00, 1'b1, 4'b0010, 0);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
